// File: rtl/dispatcher_pkg.sv
// Shared types and constants for the dispatcher FIFO path.
// Buffer depth, occupancy type and entry payload.
package dispatcher_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int ENTRY_W   = 8;

  typedef logic [1:0]         occ_t;
  typedef logic [ENTRY_W-1:0] entry_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register FIFO with enq/deq/flush.
// Head is registered; enq while full is dropped unless a deq frees space.
module stream_buf2
  import dispatcher_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] d0, d1;
  logic [DATA_WIDTH-1:0] d0_n, d1_n;
  occ_t                  occ_q, occ_n;
  logic                  enq_ok;

  assign enq_ok = enq && ((occ_q != occ_t'(BUF_DEPTH)) || deq);
  assign head   = d0;
  assign occ    = occ_q;

  always_comb begin
    d0_n  = d0;
    d1_n  = d1;
    occ_n = occ_q;
    if (flush) begin
      occ_n = '0;
    end else begin
      unique case ({enq_ok, deq})
        2'b10: begin
          if (occ_q == 2'd0) d0_n = enq_data;
          else               d1_n = enq_data;
          occ_n = occ_q + 2'd1;
        end
        2'b01: begin
          d0_n  = d1;
          occ_n = occ_q - 2'd1;
        end
        2'b11: begin
          // Head shifts out and the tail takes the new entry.
          if (occ_q == 2'd1) begin
            d0_n = enq_data;
          end else begin
            d0_n = d1;
            d1_n = enq_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0    <= '0;
      d1    <= '0;
      occ_q <= '0;
    end else begin
      d0    <= d0_n;
      d1    <= d1_n;
      occ_q <= occ_n;
    end
  end

endmodule

// File: rtl/fifo_pop_stream.sv
// Pop-side adapter: drives FIFO pop, absorbs the registered read,
// and presents entries on a bubble-free valid/ready stream.
module fifo_pop_stream
  import dispatcher_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_pop_data,
  input  logic                  fifo_pop_data_valid,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  delivered_count,
  output logic                  proto_err
);

  logic       inflight;
  logic       deq;
  logic       enq;
  logic [2:0] level;

  assign out_valid = (occupancy != 2'd0);
  assign deq       = out_valid && out_ready;
  assign enq       = fifo_pop_data_valid && !flush;

  // Entries committed after this cycle; deq implies occupancy >= 1.
  assign level = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, deq};
  assign fifo_pop = !fifo_empty && !flush && (level < 3'd2);

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq      (enq),
    .enq_data (fifo_pop_data),
    .deq      (deq),
    .flush    (flush),
    .head     (out_data),
    .occ      (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight        <= 1'b0;
      delivered_count <= '0;
      proto_err       <= 1'b0;
    end else begin
      inflight <= fifo_pop;
      if (deq) delivered_count <= delivered_count + CNT_WIDTH'(1);
      if (fifo_pop_data_valid && !inflight) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed bench for fifo_pop_stream with a behavioural
// registered-read FIFO driving the pop port.
module tb_fifo_pop_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [7:0]  fifo_pop_data;
  logic        fifo_pop_data_valid;
  logic        flush;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  occupancy;
  logic [15:0] delivered_count;
  logic        proto_err;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mem [0:63];
  int         wr = 0;
  int         rd = 0;
  logic       ret_v;
  logic [7:0] ret_d;
  logic       inj_v = 1'b0;
  logic [7:0] inj_d = 8'h00;

  always #5 clk = ~clk;

  assign fifo_empty          = (wr == rd);
  assign fifo_pop_data_valid = ret_v | inj_v;
  assign fifo_pop_data       = inj_v ? inj_d : ret_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_v <= 1'b0;
      ret_d <= 8'h00;
    end else begin
      ret_v <= fifo_pop;
      if (fifo_pop) begin
        ret_d <= mem[rd % 64];
        rd    <= rd + 1;
      end
    end
  end

  fifo_pop_stream #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (16)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fifo_empty          (fifo_empty),
    .fifo_pop            (fifo_pop),
    .fifo_pop_data       (fifo_pop_data),
    .fifo_pop_data_valid (fifo_pop_data_valid),
    .flush               (flush),
    .out_valid           (out_valid),
    .out_data            (out_data),
    .out_ready           (out_ready),
    .occupancy           (occupancy),
    .delivered_count     (delivered_count),
    .proto_err           (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr % 64] = v;
    wr++;
  endtask

  int npop;
  int seen;
  int base;
  int derr;
  int cyc;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    #12;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_cnt", 32'(delivered_count), 0);
    chk("rst_err", 32'(proto_err), 0);
    chk("rst_pop", 32'(fifo_pop), 0);
    rst_n = 1'b1;
    step();

    // 1: single entry latency
    out_ready = 1'b1;
    push(8'hA5);
    @(negedge clk); chk("t1_pop_c0", 32'(fifo_pop), 1);
    step();
    @(negedge clk); chk("t1_pop_c1", 32'(fifo_pop), 0);
    chk("t1_valid_c1", 32'(out_valid), 0);
    step();
    @(negedge clk); chk("t1_valid_c2", 32'(out_valid), 1);
    chk("t1_data_c2", 32'(out_data), 32'hA5);
    step();
    @(negedge clk); chk("t1_cnt_c3", 32'(delivered_count), 1);
    chk("t1_valid_c3", 32'(out_valid), 0);
    step();

    // 2: full-rate stream
    for (int i = 1; i <= 4; i++) push(8'(i));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("t2_pop_c%0d", c), 32'(fifo_pop), (c < 4) ? 1 : 0);
      if (c >= 2) begin
        chk($sformatf("t2_valid_c%0d", c), 32'(out_valid), 1);
        chk($sformatf("t2_data_c%0d", c), 32'(out_data), c - 1);
      end
      if (c == 3) chk("t2_occ_c3", 32'(occupancy), 1);
      step();
    end
    @(negedge clk); chk("t2_cnt", 32'(delivered_count), 5);
    chk("t2_valid_end", 32'(out_valid), 0);
    step();

    // 3: backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    npop = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fifo_pop) npop++;
      step();
    end
    chk("t3_npop", 32'(npop), 2);
    @(negedge clk); chk("t3_occ", 32'(occupancy), 2);
    chk("t3_pop_held", 32'(fifo_pop), 0);
    chk("t3_head", 32'(out_data), 1);
    step();
    out_ready = 1'b1;
    @(negedge clk); chk("t3_pop_resume", 32'(fifo_pop), 1);
    chk("t3_d1", 32'(out_data), 1);
    step();
    @(negedge clk); chk("t3_d2", 32'(out_data), 2);
    chk("t3_v2", 32'(out_valid), 1);
    chk("t3_pop2", 32'(fifo_pop), 1);
    step();
    @(negedge clk); chk("t3_d3", 32'(out_data), 3);
    step();
    @(negedge clk); chk("t3_d4", 32'(out_data), 4);
    step();
    @(negedge clk); chk("t3_valid_end", 32'(out_valid), 0);
    chk("t3_cnt", 32'(delivered_count), 9);
    step();

    // 4a: flush with a full buffer, deq in the flush cycle
    out_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    step(); step(); step();
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk); chk("t4a_occ_pre", 32'(occupancy), 2);
    chk("t4a_pop_flush", 32'(fifo_pop), 0);
    chk("t4a_head", 32'(out_data), 32'h11);
    step();
    flush = 1'b0;
    @(negedge clk); chk("t4a_valid_post", 32'(out_valid), 0);
    chk("t4a_occ_post", 32'(occupancy), 0);
    chk("t4a_cnt", 32'(delivered_count), 10);
    chk("t4a_pop_post", 32'(fifo_pop), 1);
    step();
    @(negedge clk); chk("t4a_valid_c5", 32'(out_valid), 0);
    step();
    @(negedge clk); chk("t4a_valid_c6", 32'(out_valid), 1);
    chk("t4a_data_c6", 32'(out_data), 32'h33);
    step();
    @(negedge clk); chk("t4a_cnt_end", 32'(delivered_count), 11);
    step();

    // 4b: flush drops a return in flight
    push(8'h55); push(8'h66);
    @(negedge clk); chk("t4b_pop_c0", 32'(fifo_pop), 1);
    step();
    flush = 1'b1;
    @(negedge clk); chk("t4b_pop_flush", 32'(fifo_pop), 0);
    chk("t4b_ret", 32'(fifo_pop_data_valid), 1);
    step();
    flush = 1'b0;
    @(negedge clk); chk("t4b_valid_c2", 32'(out_valid), 0);
    chk("t4b_occ_c2", 32'(occupancy), 0);
    chk("t4b_pop_c2", 32'(fifo_pop), 1);
    step();
    @(negedge clk); chk("t4b_valid_c3", 32'(out_valid), 0);
    step();
    @(negedge clk); chk("t4b_valid_c4", 32'(out_valid), 1);
    chk("t4b_data_c4", 32'(out_data), 32'h66);
    step();
    @(negedge clk); chk("t4b_cnt", 32'(delivered_count), 12);
    step();

    // 5: protocol error
    inj_v = 1'b1;
    inj_d = 8'h77;
    @(negedge clk); chk("t5_err_c0", 32'(proto_err), 0);
    step();
    inj_v = 1'b0;
    @(negedge clk); chk("t5_err_c1", 32'(proto_err), 1);
    chk("t5_valid_c1", 32'(out_valid), 1);
    chk("t5_data_c1", 32'(out_data), 32'h77);
    step();
    push(8'h5A);
    step(); step(); step();
    @(negedge clk); chk("t5_err_traffic", 32'(proto_err), 1);
    chk("t5_cnt", 32'(delivered_count), 14);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk); chk("t5_err_flush", 32'(proto_err), 1);
    step();
    rst_n = 1'b0;
    @(negedge clk); chk("t5_err_rst", 32'(proto_err), 0);
    chk("t5_cnt_rst", 32'(delivered_count), 0);
    rst_n = 1'b1;
    step();
    inj_v = 1'b1;
    inj_d = 8'h3C;
    step();
    inj_v = 1'b0;
    @(negedge clk); chk("t5_err_after_rst", 32'(proto_err), 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // 6: delivered_count wrap with ordering check
    out_ready = 1'b1;
    seen = 0;
    derr = 0;
    base = wr;
    cyc = 0;
    while (cyc < 70000 && seen < 65537) begin
      if (wr - rd < 4) push(8'(wr));
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (out_data !== 8'(base + seen)) derr++;
        seen++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("t6_seen", 32'(seen), 65537);
    chk("t6_order_errs", 32'(derr), 0);
    chk("t6_cnt_wrap", 32'(delivered_count), 1);
    chk("t6_err", 32'(proto_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
